huffman_bit_packer: RTL and testbench
=====================================

# huffman_bit_packer

Downstream stage of the static-table Huffman encoder. Accepts one right-aligned variable-length code word per handshake, concatenates code bits MSB-first into a continuous bitstream, and emits packed bytes on a ready/valid output toward the byte sink (UART TX / FIFO). An explicit flush drains residual bits as a zero-padded final byte tagged with `out_last`.

## Interface
- `ACC_W`, 16: bit accumulator width; must be ≥ 2×`MAX_LEN`.
- `MAX_LEN`, 8: maximum code length in bits; longer `in_len` values are clamped to this.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: code word present.
- `in_code` in 8: code bits, right-aligned; only the low `in_len` bits are used, sent MSB-first.
- `in_len` in 4: code length, 0..8; 0 accepted as a no-op; 9..15 clamped to 8.
- `in_ready` out 1: packer can take a code this cycle.
- `flush` in 1: single-cycle request to drain residual bits.
- `out_valid` out 1: `out_byte` holds a packed byte.
- `out_byte` out 8: packed byte; first stream bit in bit 7.
- `out_last` out 1: qualifies the final byte of a flush.
- `out_ready` in 1: sink accepts `out_byte`.
- `flush_done` out 1: one-cycle pulse when a flush has fully completed.

## Operation
- State: `acc[ACC_W-1:0]` (left-aligned valid bits), `cnt[4:0]` (0..16 valid bits), one-entry output register (`out_byte`, `out_valid`, `out_last`), FSM {RUN, FLUSH}.
- `in_ready` = (state == RUN) && (`cnt` ≤ 8); combinational from registers only.
- Accept: `in_valid && in_ready`. Drain: `cnt` ≥ 8 && (!`out_valid` || `out_ready`); loads `acc[15:8]` into the output register, shifts `acc` left by 8, `cnt` -= 8.
- Accept and drain can occur in the same cycle: new code is inserted after the post-drain bits; `cnt_next` = `cnt` − 8·drain + len. Bits below `cnt` in `acc` are always zero.
- Output register holds `out_byte`/`out_last` stable while `out_valid && !out_ready`; `out_valid` clears on handshake when no new drain occurs.
- RUN → FLUSH on edge where `flush` is 1; a code accepted in that same cycle is included in the flush. `flush` while in FLUSH is ignored.
- FLUSH: `in_ready` = 0. Full bytes drain as in RUN. When 1 ≤ `cnt` ≤ 7 and the output register is free, load `acc[15:8]` (zero LSB padding), `cnt` ← 0. The byte whose load leaves `cnt` = 0 in FLUSH carries `out_last` = 1.
- FLUSH → RUN when `cnt` = 0 and the output register is empty or completing its handshake; `flush_done` is registered high the following cycle for exactly one cycle.
- Flush with no residual bits produces no byte, only `flush_done`.

## Timing
- Reset values: `out_valid` 0, `out_byte` 8'h00, `out_last` 0, `flush_done` 0, `acc` 0, `cnt` 0, state RUN; hence `in_ready` = 1.
- `rst_n` low mid-operation: all buffered bits and any pending output byte discarded immediately; no partial byte ever emitted.
- Latency: code completing a byte accepted at edge N → `out_valid` high after edge N+1.
- Throughput: one byte per cycle with `out_ready` held high; one code per cycle while `cnt` ≤ 8.
- Backpressure: with output register full, at most 16 bits buffered; `in_ready` falls when `cnt` > 8.

## Test plan
- Reset: hold `rst_n` low → all outputs 0, `in_ready` 1 after release.
- Codes 4'b1010 (len 4) then 4'b0011 (len 4), `out_ready` 1 → single `out_byte` 8'hA3, `out_last` 0, valid one cycle after second accept.
- Three codes 3'b101 (len 3), then `flush` → 8'hB6 (`out_last` 0), then 8'h80 (`out_last` 1), then `flush_done` one-cycle pulse.
- `out_ready` 0, feed 8-bit 8'hFF, 8'h00, 8'h55 → `in_ready` drops after third accept (`cnt` 16), `out_byte` stable at 8'hFF; release `out_ready` → 8'hFF, 8'h00, 8'h55 in order.
- `in_len` 0 code, then `flush` with empty buffer → no `out_valid`, `flush_done` high exactly two cycles after `flush` sampled; `in_len` 12 with `in_code` 8'hC3 → treated as len 8, 8'hC3 emitted.
- Accept 5 bits, pulse `rst_n` low mid-stream → `out_valid` 0 immediately; after release, `flush` yields only `flush_done`, no byte.

Source files
------------

// File: rtl/huffman_bit_packer.sv
// Packs right-aligned variable-length code words MSB-first into a byte stream.
// An explicit flush drains residual bits as a zero-padded byte tagged out_last.
module huffman_bit_packer #(
  parameter int ACC_W   = 16,
  parameter int MAX_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_code,
  input  logic [3:0] in_len,
  output logic       in_ready,
  input  logic       flush,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       out_last,
  input  logic       out_ready,
  output logic       flush_done
);

  localparam int CNT_W = $clog2(ACC_W + 1);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       out_byte_reg;
  logic             out_valid_reg;
  logic             out_last_reg;
  logic             done_pend_reg;
  logic             flush_done_reg;

  logic             out_free;
  logic             drain_full;
  logic             drain_part;
  logic             load_byte;
  logic             accept;
  logic             done_set;
  logic             last_byte;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_after;
  logic [CNT_W-1:0] ins_shift;
  logic [ACC_W-1:0] acc_after;
  logic [ACC_W-1:0] code_wide;
  logic [7:0]       code_masked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_RUN;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:   if (flush) state_next = ST_FLUSH;
      ST_FLUSH: if (cnt_reg == '0 && out_free) state_next = ST_RUN;
    endcase
  end

  // FSM outputs: input gating, padded final byte, and flush completion.
  always_comb begin
    in_ready   = (state_reg == ST_RUN) && (cnt_reg <= CNT_W'(8));
    drain_part = (state_reg == ST_FLUSH) && (cnt_reg != '0) &&
                 (cnt_reg < CNT_W'(8)) && out_free;
    done_set   = (state_reg == ST_FLUSH) && (cnt_reg == '0) && out_free;
  end

  always_comb begin
    out_free    = !out_valid_reg || out_ready;
    drain_full  = (cnt_reg >= CNT_W'(8)) && out_free;
    load_byte   = drain_full || drain_part;
    accept      = in_valid && in_ready;
    len_eff     = (in_len > 4'(MAX_LEN)) ? CNT_W'(MAX_LEN) : CNT_W'(in_len);
    code_masked = in_code & ~(8'hFF << len_eff);

    if (drain_full) begin
      acc_after = acc_reg << 8;
      cnt_after = cnt_reg - CNT_W'(8);
    end else if (drain_part) begin
      acc_after = '0;
      cnt_after = '0;
    end else begin
      acc_after = acc_reg;
      cnt_after = cnt_reg;
    end

    // New code lands directly below the bits that survive this cycle's drain.
    ins_shift = CNT_W'(ACC_W) - cnt_after - len_eff;
    code_wide = ACC_W'(code_masked) << ins_shift;

    acc_next = acc_after;
    cnt_next = cnt_after;
    if (accept) begin
      acc_next = acc_after | code_wide;
      cnt_next = cnt_after + len_eff;
    end

    last_byte = (state_reg == ST_FLUSH) && (cnt_after == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg        <= '0;
      cnt_reg        <= '0;
      out_byte_reg   <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      done_pend_reg  <= 1'b0;
      flush_done_reg <= 1'b0;
    end else begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_next;
      if (load_byte) begin
        out_byte_reg  <= acc_reg[ACC_W-1 -: 8];
        out_valid_reg <= 1'b1;
        out_last_reg  <= last_byte;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      // Completion is reported one cycle after the FSM has returned to RUN.
      done_pend_reg  <= done_set;
      flush_done_reg <= done_pend_reg;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_byte   = out_byte_reg;
  assign out_last   = out_last_reg;
  assign flush_done = flush_done_reg;

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Bench for huffman_bit_packer: directed scenarios plus random traffic
// checked against a bit-queue model of the output stream.
module tb_huffman_bit_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_code;
  logic [3:0] in_len;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_last;
  logic       out_ready;
  logic       flush_done;

  int checks   = 0;
  int failures = 0;

  huffman_bit_packer #(.ACC_W(16), .MAX_LEN(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_len     (in_len),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_byte   (out_byte),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: stream of bits, cut into bytes; last code 2 = either.
  bit         bitq[$];
  logic [7:0] exp_byte[$];
  int         exp_last[$];
  int         flush_pend = 0;
  bit         hold_prev  = 0;
  logic [7:0] prev_byte;
  logic       prev_last;

  task automatic model_cut();
    logic [7:0] b;
    while (bitq.size() >= 8) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bitq.pop_front()};
      exp_byte.push_back(b);
      exp_last.push_back(0);
    end
  endtask

  task automatic model_push(input logic [7:0] code, input logic [3:0] len);
    int l;
    l = (len > 8) ? 8 : int'(len);
    for (int i = l - 1; i >= 0; i--) bitq.push_back(code[i]);
    model_cut();
  endtask

  task automatic model_flush();
    if (bitq.size() > 0) begin
      while (bitq.size() < 8) bitq.push_back(1'b0);
      model_cut();
      exp_last[exp_last.size()-1] = 1;
    end else if (exp_last.size() > 0) begin
      // A final full byte may or may not still be waiting when the flush lands.
      exp_last[exp_last.size()-1] = 2;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      bitq.delete();
      exp_byte.delete();
      exp_last.delete();
      flush_pend = 0;
      hold_prev  = 0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_byte", out_byte, prev_byte);
        check("hold_last", out_last, prev_last);
      end
      if (in_valid && in_ready) model_push(in_code, in_len);
      if (flush) begin
        model_flush();
        flush_pend++;
      end
      if (out_valid && out_ready) begin
        $display("byte 0x%02h last=%0d", out_byte, out_last);
        check("byte_expected", exp_byte.size() != 0, 1);
        if (exp_byte.size() != 0) begin
          logic [7:0] eb;
          int         el;
          eb = exp_byte.pop_front();
          el = exp_last.pop_front();
          check("stream_byte", out_byte, eb);
          if (el != 2) check("stream_last", out_last, el);
        end
      end
      if (flush_done) begin
        check("done_pending", flush_pend > 0, 1);
        check("done_drained", exp_byte.size(), 0);
        if (flush_pend > 0) flush_pend--;
      end
      hold_prev = out_valid && !out_ready;
      prev_byte = out_byte;
      prev_last = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [3:0] l);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_code  = c;
    in_len   = l;
    while (!ok && n < 100) begin
      ok = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("send_accept", ok, 1);
  endtask

  logic [7:0] cbytes[$];
  logic       clasts[$];
  int         cdone;

  task automatic collect(input int n);
    cbytes.delete();
    clasts.delete();
    cdone = 0;
    for (int i = 0; i < n; i++) begin
      if (out_valid && out_ready) begin
        cbytes.push_back(out_byte);
        clasts.push_back(out_last);
      end
      if (flush_done) cdone++;
      tick();
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    bit flushing;
    int wait_cnt;

    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; in_len = '0;
    flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 8'h00);
    check("rst_out_last", out_last, 0);
    check("rst_flush_done", flush_done, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    // Two nibbles form one byte, one cycle after the second accept.
    send(8'h0A, 4'd4);
    send(8'h03, 4'd4);
    check("lat_early", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    check("lat_byte", out_byte, 8'hA3);
    check("lat_last", out_last, 0);
    tick();
    check("lat_one_cycle", out_valid, 0);

    // Nine bits then flush: one full byte and a padded last byte.
    send(8'h05, 4'd3);
    send(8'h05, 4'd3);
    send(8'h05, 4'd3);
    pulse_flush();
    collect(10);
    check("fl_count", cbytes.size(), 2);
    if (cbytes.size() == 2) begin
      check("fl_b0", cbytes[0], 8'hB6);
      check("fl_l0", clasts[0], 0);
      check("fl_b1", cbytes[1], 8'h80);
      check("fl_l1", clasts[1], 1);
    end
    check("fl_done", cdone, 1);

    // Backpressure: 16 bits buffered behind a stalled output register.
    out_ready = 1'b0;
    send(8'hFF, 4'd8);
    send(8'h00, 4'd8);
    send(8'h55, 4'd8);
    check("bp_in_ready", in_ready, 0);
    tick(); tick(); tick();
    check("bp_valid", out_valid, 1);
    check("bp_byte", out_byte, 8'hFF);
    check("bp_in_ready_hold", in_ready, 0);
    out_ready = 1'b1;
    collect(6);
    check("bp_count", cbytes.size(), 3);
    if (cbytes.size() == 3) begin
      check("bp_b0", cbytes[0], 8'hFF);
      check("bp_b1", cbytes[1], 8'h00);
      check("bp_b2", cbytes[2], 8'h55);
    end

    // Zero-length code, then empty flush: only flush_done, two cycles later.
    send(8'h5A, 4'd0);
    pulse_flush();
    check("ef_done_d0", flush_done, 0);
    tick();
    check("ef_done_d1", flush_done, 0);
    tick();
    check("ef_done_d2", flush_done, 1);
    check("ef_no_byte", out_valid, 0);
    tick();
    check("ef_done_d3", flush_done, 0);
    send(8'hC3, 4'd12);
    collect(4);
    check("clamp_count", cbytes.size(), 1);
    if (cbytes.size() == 1) check("clamp_byte", cbytes[0], 8'hC3);

    // Reset mid-stream discards a pending byte and residual bits.
    out_ready = 1'b0;
    send(8'hFF, 4'd8);
    send(8'h16, 4'd5);
    tick();
    check("mr_pending", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_byte", out_byte, 8'h00);
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    pulse_flush();
    collect(8);
    check("mr_no_byte", cbytes.size(), 0);
    check("mr_done", cdone, 1);

    // Random traffic; flushes issued only while the packer is idle in RUN.
    flushing = 0;
    wait_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (flushing) begin
        in_valid = 1'b0;
        flush    = 1'b0;
        wait_cnt++;
        if (flush_done) flushing = 0;
        else if (wait_cnt > 300) begin
          check("rand_flush_timeout", flush_done, 1);
          flushing = 0;
        end
      end else begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_code  = 8'($urandom);
        in_len   = 4'($urandom_range(0, 15));
        flush    = ($urandom_range(0, 39) == 0);
        if (flush) begin
          flushing = 1;
          wait_cnt = 0;
        end
      end
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end

    in_valid = 1'b0;
    flush    = 1'b0;
    out_ready = 1'b1;
    wait_cnt = 0;
    while (flushing && !flush_done && wait_cnt < 300) begin
      tick();
      wait_cnt++;
    end
    tick();
    pulse_flush();
    wait_cnt = 0;
    while (!flush_done && wait_cnt < 300) begin
      tick();
      wait_cnt++;
    end
    check("final_flush_done", flush_done, 1);
    tick();
    check("final_queue_empty", exp_byte.size(), 0);
    check("final_bits_empty", bitq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
